// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame sequencer.
// Byte/address widths and the shifter's per-byte cost are fixed by the 74HC595 chain driver.
package led_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned ADDR_W     = 4;
  localparam int unsigned SFT_CYCLES = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WAIT   = 3'd2,
    SETTLE = 3'd3,
    LATCH  = 3'd4
  } state_t;

endpackage

// File: rtl/led_refresh_if.sv
// Shadow-write bus from the register bank plus the byte handshake to the LED shifter.
// master drives writes and shift-complete; slave is the frame sequencer.
interface led_refresh_if;
  import led_pkg::*;

  logic              wr_en;
  logic              wr_sel;
  logic [ADDR_W-1:0] wr_addr;
  logic [BYTE_W-1:0] wr_data;
  logic              sft_vld;
  logic [BYTE_W-1:0] sft_din;
  logic              sft_done;
  logic              sft_stcp;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, sft_done,
    input  sft_vld, sft_din, sft_stcp
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, sft_done,
    output sft_vld, sft_din, sft_stcp
  );

endinterface

// File: rtl/led_blink_tmr.sv
// Blink prescaler: counts BLINK_DIV clocks per half-period, flips phase at the wrap
// and raises toggle for the one cycle in which the new phase first appears.
module led_blink_tmr #(
  parameter int unsigned BLINK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  output logic phase,
  output logic toggle
);

  localparam int unsigned CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             phase_r;
  logic             toggle_r;

  // Prescaler count, phase flip and toggle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CNT_W{1'b0}};
      phase_r  <= 1'b0;
      toggle_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r    <= {CNT_W{1'b0}};
      phase_r  <= ~phase_r;
      toggle_r <= 1'b1;
    end else begin
      cnt_r    <= cnt_r + CNT_W'(1'b1);
      toggle_r <= 1'b0;
    end
  end

  assign phase  = phase_r;
  assign toggle = toggle_r;

endmodule

// File: rtl/led_refresh.sv
// Frame sequencer for a chain of 74HC595 LED drivers: keeps shadow LED/blink bytes,
// streams them highest index first to the shifter and then pulses the storage clock.
module led_refresh
  import led_pkg::*;
#(
  parameter int unsigned NUM_BYTES  = 4,
  parameter int unsigned BLINK_DIV  = 24'd12_500_000,
  parameter int unsigned STCP_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  led_refresh_if.slave  bus,
  output logic          busy
);

  localparam int unsigned STCP_CW = (STCP_WIDTH > 1) ? $clog2(STCP_WIDTH) : 1;
  localparam logic [STCP_CW-1:0] STCP_LAST  = STCP_CW'(STCP_WIDTH - 1);
  localparam logic [ADDR_W-1:0]  IDX_TOP    = ADDR_W'(NUM_BYTES - 1);
  localparam logic [ADDR_W:0]    ADDR_LIMIT = (ADDR_W + 1)'(NUM_BYTES);

  logic [BYTE_W-1:0]  led_r   [NUM_BYTES];
  logic [BYTE_W-1:0]  blink_r [NUM_BYTES];
  state_t             state_r, state_s;
  logic [ADDR_W-1:0]  idx_r, idx_s;
  logic [STCP_CW-1:0] stcp_cnt_r, stcp_cnt_s;
  logic               dirty_r;
  logic               phase_s, toggle_s;
  logic               wr_ok_s, blink_any_s;
  logic [BYTE_W-1:0]  cur_byte_s;

  led_blink_tmr #(.BLINK_DIV(BLINK_DIV)) u_blink_tmr (
    .clk    (clk),
    .rst    (rst),
    .phase  (phase_s),
    .toggle (toggle_s)
  );

  // Addresses beyond the chain are dropped entirely, including their dirty effect.
  assign wr_ok_s = bus.wr_en && ({1'b0, bus.wr_addr} < ADDR_LIMIT);

  // Shadow LED and blink-mask byte storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        led_r[i]   <= 8'h00;
        blink_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < int'(NUM_BYTES); i++) begin
        if (wr_ok_s && (bus.wr_addr == ADDR_W'(i))) begin
          if (bus.wr_sel) begin
            blink_r[i] <= bus.wr_data;
          end else begin
            led_r[i] <= bus.wr_data;
          end
        end
      end
    end
  end

  // Live byte select with blink masking, plus any-blink detect.
  always_comb begin
    cur_byte_s  = {BYTE_W{1'b0}};
    blink_any_s = 1'b0;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      blink_any_s = blink_any_s | (blink_r[i] != 8'h00);
      cur_byte_s  = (idx_r == ADDR_W'(i)) ? (led_r[i] & ~(blink_r[i] & {BYTE_W{phase_s}}))
                                          : cur_byte_s;
    end
  end

  // Refresh request: set wins over the IDLE consume so a racing write is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      dirty_r <= 1'b1;
    end else if (wr_ok_s || (toggle_s && blink_any_s)) begin
      dirty_r <= 1'b1;
    end else if (state_r == IDLE) begin
      dirty_r <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= {ADDR_W{1'b0}};
      stcp_cnt_r <= {STCP_CW{1'b0}};
    end else begin
      state_r    <= state_s;
      idx_r      <= idx_s;
      stcp_cnt_r <= stcp_cnt_s;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    stcp_cnt_s = stcp_cnt_r;
    case (state_r)
      IDLE: begin
        if (dirty_r) begin
          idx_s   = IDX_TOP;
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = WAIT;
      WAIT: begin
        if (bus.sft_done) begin
          if (idx_r == {ADDR_W{1'b0}}) begin
            state_s = SETTLE;
          end else begin
            idx_s   = idx_r - ADDR_W'(1'b1);
            state_s = LOAD;
          end
        end else begin
          state_s = WAIT;
        end
      end
      // One quiet cycle so stcp never rises with the final shift clock edge.
      SETTLE: begin
        stcp_cnt_s = {STCP_CW{1'b0}};
        state_s    = LATCH;
      end
      LATCH: begin
        if (stcp_cnt_r == STCP_LAST) begin
          state_s = IDLE;
        end else begin
          stcp_cnt_s = stcp_cnt_r + STCP_CW'(1'b1);
          state_s    = LATCH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Outputs decode registered state only; din reflects shadow registers at LOAD.
  assign bus.sft_vld  = (state_r == LOAD);
  assign bus.sft_din  = (state_r == LOAD) ? cur_byte_s : 8'h00;
  assign bus.sft_stcp = (state_r == LATCH);
  assign busy         = (state_r != IDLE);

endmodule
